// File: rtl/uart_link_sched.sv
// uart_link_sched
// Owns the UART frame buffers. Arbitrates two transmit requesters onto the
// single downstream RAM/engine, sequences the start level and length, and
// estimates TX completion with a byte-time timer. On the receive side it
// turns the engine's frame flag into an irq/ack handshake with a timed clear.
// Optional feature macro: UART_SCHED_RR_EN selects round-robin arbitration;
// left undefined, req0 has fixed priority over req1.
module uart_link_sched #(
    parameter int START_HOLD   = 4,
    parameter int CLR_HOLD     = 4,
    parameter int BYTE_CYCLES  = 10850,
    parameter int GUARD_CYCLES = 1000,
    parameter int FLAG_TMO     = 1024
) (
    input  logic        clk_125m,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [7:0]  req0_len,
    output logic        req0_ready,
    output logic        req0_done,
    input  logic        req1_valid,
    input  logic [7:0]  req1_len,
    output logic        req1_ready,
    output logic        req1_done,
    output logic        tx_busy,
    output logic        tx_owner,
    output logic        ram_uart_down_start,
    output logic [7:0]  ram_uart_down_len,
    input  logic        ram_uart_up_flag,
    input  logic [12:0] ram_uart_up_len,
    output logic        ram_uart_up_clr,
    output logic        rx_irq,
    output logic [12:0] rx_len,
    input  logic        rx_ack,
    output logic        rx_err
);

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_START = 2'd1;
    localparam logic [1:0] T_WAIT  = 2'd2;
    localparam logic [1:0] T_DONE  = 2'd3;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_PEND  = 2'd1;
    localparam logic [1:0] R_CLR   = 2'd2;
    localparam logic [1:0] R_DROP  = 2'd3;

    // Hold counters count down to zero, so they are loaded with HOLD-1.
    localparam logic [23:0] START_LAST = 24'(START_HOLD - 1);
    localparam logic [23:0] BYTE_C     = 24'(BYTE_CYCLES);
    localparam logic [23:0] GUARD_C    = 24'(GUARD_CYCLES);
    // The RX counter is 16 bits wide; FLAG_TMO and CLR_HOLD must fit in it.
    localparam logic [15:0] CLR_LAST   = 16'(CLR_HOLD - 1);
    localparam logic [15:0] TMO_LAST   = 16'(FLAG_TMO - 1);

    logic [1:0]  txState_q, txState_d;
    logic [23:0] txCnt_q, txCnt_d;
    logic [7:0]  downLen_q, downLen_d;
    logic        owner_q, owner_d;
    logic        grant;
    logic        grantSel;
    logic [7:0]  selLen;
    logic [23:0] waitLoad;

    logic [1:0]  rxState_q, rxState_d;
    logic [15:0] rxCnt_q, rxCnt_d;
    logic [12:0] rxLen_q, rxLen_d;
    logic        rxErr_q, rxErr_d;

`ifdef UART_SCHED_RR_EN
    logic        pref_q, pref_d;

    // Pick the requester to serve: on a tie the one not served last wins.
    always_comb begin
        grantSel = req1_valid;
        if (req0_valid && req1_valid) begin
            grantSel = pref_q;
        end
    end

    // Tie-break preference flips away from whoever was just granted.
    always_comb begin
        pref_d = pref_q;
        if (grant) begin
            pref_d = ~grantSel;
        end
    end

    // Preference register; reset favours req0.
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            pref_q <= 1'b0;
        end else begin
            pref_q <= pref_d;
        end
    end
`else
    // Pick the requester to serve: req0 always wins when it is asking.
    always_comb begin
        grantSel = ~req0_valid;
    end
`endif

    // Ready is combinational in the idle cycle and forced low while in reset.
    assign grant    = rst_n && (txState_q == T_IDLE) && (req0_valid || req1_valid);
    assign selLen   = grantSel ? req1_len : req0_len;
    // 8x24 multiply truncated to the 24-bit counter width.
    assign waitLoad = ({16'd0, downLen_q} * BYTE_C) + GUARD_C;

    // TX sequencing: grant, hold start, wait out the estimated byte time, report done.
    always_comb begin
        txState_d = txState_q;
        txCnt_d   = txCnt_q;
        downLen_d = downLen_q;
        owner_d   = owner_q;
        case (txState_q)
            T_IDLE: begin
                if (grant) begin
                    downLen_d = selLen;
                    owner_d   = grantSel;
                    if (selLen != 8'd0) begin
                        txCnt_d   = START_LAST;
                        txState_d = T_START;
                    end else begin
                        // Length 0 would make the engine send 256 bytes, so skip the start.
                        txState_d = T_DONE;
                    end
                end
            end
            T_START: begin
                if (txCnt_q == 24'd0) begin
                    txCnt_d   = waitLoad;
                    txState_d = T_WAIT;
                end else begin
                    txCnt_d = txCnt_q - 24'd1;
                end
            end
            T_WAIT: begin
                if (txCnt_q <= 24'd1) begin
                    txCnt_d   = 24'd0;
                    txState_d = T_DONE;
                end else begin
                    txCnt_d = txCnt_q - 24'd1;
                end
            end
            T_DONE: begin
                txState_d = T_IDLE;
            end
            default: begin
                txState_d = T_IDLE;
            end
        endcase
    end

    // TX state registers.
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            txState_q <= T_IDLE;
            txCnt_q   <= 24'd0;
            downLen_q <= 8'd0;
            owner_q   <= 1'b0;
        end else begin
            txState_q <= txState_d;
            txCnt_q   <= txCnt_d;
            downLen_q <= downLen_d;
            owner_q   <= owner_d;
        end
    end

    assign req0_ready          = grant && !grantSel;
    assign req1_ready          = grant && grantSel;
    assign req0_done           = (txState_q == T_DONE) && !owner_q;
    assign req1_done           = (txState_q == T_DONE) && owner_q;
    assign tx_busy             = (txState_q != T_IDLE);
    assign tx_owner            = owner_q;
    assign ram_uart_down_start = (txState_q == T_START);
    assign ram_uart_down_len   = downLen_q;

    // RX handshake: capture frame, wait for ack, pulse clear, wait for the flag to drop.
    always_comb begin
        rxState_d = rxState_q;
        rxCnt_d   = rxCnt_q;
        rxLen_d   = rxLen_q;
        rxErr_d   = 1'b0;
        case (rxState_q)
            R_IDLE: begin
                if (ram_uart_up_flag) begin
                    rxLen_d   = ram_uart_up_len;
                    rxState_d = R_PEND;
                end
            end
            R_PEND: begin
                if (rx_ack) begin
                    rxCnt_d   = CLR_LAST;
                    rxState_d = R_CLR;
                end
            end
            R_CLR: begin
                if (rxCnt_q == 16'd0) begin
                    rxCnt_d   = TMO_LAST;
                    rxState_d = R_DROP;
                end else begin
                    rxCnt_d = rxCnt_q - 16'd1;
                end
            end
            R_DROP: begin
                if (!ram_uart_up_flag) begin
                    rxCnt_d   = 16'd0;
                    rxState_d = R_IDLE;
                end else if (rxCnt_q == 16'd0) begin
                    // Flag stuck high: report it; idle will re-raise the frame.
                    rxErr_d   = 1'b1;
                    rxState_d = R_IDLE;
                end else begin
                    rxCnt_d = rxCnt_q - 16'd1;
                end
            end
            default: begin
                rxState_d = R_IDLE;
            end
        endcase
    end

    // RX state registers.
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            rxState_q <= R_IDLE;
            rxCnt_q   <= 16'd0;
            rxLen_q   <= 13'd0;
            rxErr_q   <= 1'b0;
        end else begin
            rxState_q <= rxState_d;
            rxCnt_q   <= rxCnt_d;
            rxLen_q   <= rxLen_d;
            rxErr_q   <= rxErr_d;
        end
    end

    assign ram_uart_up_clr = (rxState_q == R_CLR);
    assign rx_irq          = (rxState_q == R_PEND);
    assign rx_len          = rxLen_q;
    assign rx_err          = rxErr_q;

endmodule

// File: tb/tb_uart_link_sched.sv
// tb_uart_link_sched
// Self-checking bench for uart_link_sched with short timing parameters.
// Expectations follow UART_SCHED_RR_EN when it is defined.
module tb_uart_link_sched;

    localparam int SH  = 4;
    localparam int CH  = 4;
    localparam int BC  = 10;
    localparam int GC  = 5;
    localparam int TMO = 16;

    logic        clk_125m = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_len, req1_len;
    logic        req0_ready, req1_ready, req0_done, req1_done;
    logic        tx_busy, tx_owner, ram_uart_down_start;
    logic [7:0]  ram_uart_down_len;
    logic        ram_uart_up_flag;
    logic [12:0] ram_uart_up_len;
    logic        ram_uart_up_clr, rx_irq, rx_ack, rx_err;
    logic [12:0] rx_len;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int reqIdx;
        int len;
        int expDoneOff;
        int expStartFirst;
        int expStartCnt;
    } txVec_t;

    txVec_t      vecs [6];
    logic [1:0]  resReady;
    int          resDoneOff, resStartFirst, resStartCnt, resWrongDone;
    logic [31:0] resDownLen, resOwner, resBusyAfter;

    int          order [3];
    int          expOrder [3];
    int          grants, bothHigh, doneSeen, startSeen;

    bit          mActive, mOwner, mPref, visOwner, sel, idle;
    bit          eR0, eR1, eD0, eD1, eStart, eBusy;
    int          mG, mL, mDone, visLen;
    bit          v [2];
    int          ln [2];
    logic [14:0] expV, actV;
    logic [2:0]  rxExp, rxAct;

    always #4 clk_125m = ~clk_125m;

    uart_link_sched #(
        .START_HOLD  (SH),
        .CLR_HOLD    (CH),
        .BYTE_CYCLES (BC),
        .GUARD_CYCLES(GC),
        .FLAG_TMO    (TMO)
    ) dut (
        .clk_125m           (clk_125m),
        .rst_n              (rst_n),
        .req0_valid         (req0_valid),
        .req0_len           (req0_len),
        .req0_ready         (req0_ready),
        .req0_done          (req0_done),
        .req1_valid         (req1_valid),
        .req1_len           (req1_len),
        .req1_ready         (req1_ready),
        .req1_done          (req1_done),
        .tx_busy            (tx_busy),
        .tx_owner           (tx_owner),
        .ram_uart_down_start(ram_uart_down_start),
        .ram_uart_down_len  (ram_uart_down_len),
        .ram_uart_up_flag   (ram_uart_up_flag),
        .ram_uart_up_len    (ram_uart_up_len),
        .ram_uart_up_clr    (ram_uart_up_clr),
        .rx_irq             (rx_irq),
        .rx_len             (rx_len),
        .rx_ack             (rx_ack),
        .rx_err             (rx_err)
    );

    // Compare one observed value against its required value.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Move just past the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk_125m);
        #1;
    endtask

    // Pulse reset for a few cycles with all inputs quiet.
    task automatic doReset();
        rst_n            = 1'b0;
        req0_valid       = 1'b0;
        req1_valid       = 1'b0;
        rx_ack           = 1'b0;
        ram_uart_up_flag = 1'b0;
        repeat (3) @(negedge clk_125m);
        tick();
        rst_n = 1'b1;
    endtask

    // Wait (bounded) until the TX side is idle again.
    task automatic waitIdle(input string name);
        for (int k = 0; k < 3000 && tx_busy; k++) @(negedge clk_125m);
        @(negedge clk_125m);
        checkOutput(name, tx_busy, 0);
    endtask

    // Issue one request and measure grant, start window, done offset and idle return.
    task automatic applyStimulus(input txVec_t tv);
        logic ownDone, otherDone;
        tick();
        if (tv.reqIdx == 0) begin
            req0_valid = 1'b1;
            req0_len   = 8'(tv.len);
        end else begin
            req1_valid = 1'b1;
            req1_len   = 8'(tv.len);
        end
        @(negedge clk_125m);
        resReady = {req0_ready, req1_ready};
        tick();
        req0_valid    = 1'b0;
        req1_valid    = 1'b0;
        resDoneOff    = -1;
        resStartFirst = -1;
        resStartCnt   = 0;
        resWrongDone  = 0;
        resBusyAfter  = 32'hffff_ffff;
        resDownLen    = 32'hffff_ffff;
        resOwner      = 32'hffff_ffff;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk_125m);
            if (k == 1) begin
                resDownLen = 32'(ram_uart_down_len);
                resOwner   = 32'(tx_owner);
            end
            if (ram_uart_down_start) begin
                resStartCnt++;
                if (resStartFirst < 0) resStartFirst = k;
            end
            if (resDoneOff >= 0) begin
                resBusyAfter = 32'(tx_busy);
                break;
            end
            ownDone   = (tv.reqIdx == 0) ? req0_done : req1_done;
            otherDone = (tv.reqIdx == 0) ? req1_done : req0_done;
            if (otherDone) resWrongDone++;
            if (ownDone) resDoneOff = k;
        end
    endtask

    initial begin
        // Offsets are counted in cycles from the grant cycle.
        vecs[0] = '{reqIdx: 0, len: 3,   expDoneOff: 40,   expStartFirst: 1,  expStartCnt: 4};
        vecs[1] = '{reqIdx: 1, len: 0,   expDoneOff: 1,    expStartFirst: -1, expStartCnt: 0};
        vecs[2] = '{reqIdx: 1, len: 2,   expDoneOff: 30,   expStartFirst: 1,  expStartCnt: 4};
        vecs[3] = '{reqIdx: 0, len: 1,   expDoneOff: 20,   expStartFirst: 1,  expStartCnt: 4};
        vecs[4] = '{reqIdx: 1, len: 255, expDoneOff: 2560, expStartFirst: 1,  expStartCnt: 4};
        vecs[5] = '{reqIdx: 0, len: 0,   expDoneOff: 1,    expStartFirst: -1, expStartCnt: 0};

        // Reset state with busy-looking inputs: every output must read zero.
        rst_n            = 1'b0;
        req0_valid       = 1'b1;
        req0_len         = 8'd7;
        req1_valid       = 1'b1;
        req1_len         = 8'd9;
        ram_uart_up_flag = 1'b1;
        ram_uart_up_len  = 13'h055;
        rx_ack           = 1'b1;
        @(negedge clk_125m);
        @(negedge clk_125m);
        checkOutput("reset_outputs",
                    {req0_ready, req1_ready, req0_done, req1_done, tx_busy, tx_owner,
                     ram_uart_down_start, ram_uart_down_len, ram_uart_up_clr, rx_irq, rx_len, rx_err},
                    0);
        doReset();

        // Table-driven single requests.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_ready", i), resReady, (vecs[i].reqIdx == 0) ? 2'b10 : 2'b01);
            checkOutput($sformatf("vec%0d_done_off", i), resDoneOff, vecs[i].expDoneOff);
            checkOutput($sformatf("vec%0d_start_first", i), resStartFirst, vecs[i].expStartFirst);
            checkOutput($sformatf("vec%0d_start_cnt", i), resStartCnt, vecs[i].expStartCnt);
            checkOutput($sformatf("vec%0d_down_len", i), resDownLen, vecs[i].len);
            checkOutput($sformatf("vec%0d_owner", i), resOwner, vecs[i].reqIdx);
            checkOutput($sformatf("vec%0d_busy_after", i), resBusyAfter, 0);
            checkOutput($sformatf("vec%0d_wrong_done", i), resWrongDone, 0);
        end

        // Contention: both requesters valid continuously, length 1.
        doReset();
`ifdef UART_SCHED_RR_EN
        expOrder[0] = 0; expOrder[1] = 1; expOrder[2] = 0;
`else
        expOrder[0] = 0; expOrder[1] = 0; expOrder[2] = 0;
`endif
        for (int i = 0; i < 3; i++) order[i] = -1;
        grants   = 0;
        bothHigh = 0;
        tick();
        req0_valid = 1'b1; req0_len = 8'd1;
        req1_valid = 1'b1; req1_len = 8'd1;
        for (int k = 0; k < 200 && grants < 3; k++) begin
            @(negedge clk_125m);
            if (req0_ready && req1_ready) bothHigh++;
            if (req0_ready) begin
                order[grants] = 0;
                grants++;
            end else if (req1_ready) begin
                order[grants] = 1;
                grants++;
            end
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) checkOutput($sformatf("contend_grant%0d", i), order[i], expOrder[i]);
        checkOutput("contend_both_ready", bothHigh, 0);
        waitIdle("contend_idle");

        // RX handshake with the flag dropping after the clear.
        tick();
        ram_uart_up_flag = 1'b1;
        ram_uart_up_len  = 13'h012;
        @(negedge clk_125m);
        checkOutput("rx_irq_same_cycle", rx_irq, 0);
        @(negedge clk_125m);
        checkOutput("rx_irq_next_cycle", rx_irq, 1);
        checkOutput("rx_len_capture", rx_len, 13'h012);
        tick();
        rx_ack = 1'b1;
        @(negedge clk_125m);
        checkOutput("rx_irq_ack_cycle", rx_irq, 1);
        tick();
        rx_ack = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) tick();
            if (k == 8) ram_uart_up_flag = 1'b0;
            @(negedge clk_125m);
            rxExp = {(k <= CH) ? 1'b1 : 1'b0, 1'b0, 1'b0};
            rxAct = {ram_uart_up_clr, rx_irq, rx_err};
            checkOutput($sformatf("rx_hs_k%0d_clr_irq_err", k), rxAct, rxExp);
        end
        // An ack while idle must not start a clear.
        tick();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_125m);
            if (ram_uart_up_clr || rx_irq) doneSeen++;
        end
        checkOutput("rx_stray_ack", doneSeen, 0);

        // RX timeout: the flag stays high after the clear.
        tick();
        ram_uart_up_flag = 1'b1;
        ram_uart_up_len  = 13'h1ab;
        @(negedge clk_125m);
        @(negedge clk_125m);
        checkOutput("rx_tmo_irq", rx_irq, 1);
        checkOutput("rx_tmo_len", rx_len, 13'h1ab);
        tick();
        rx_ack = 1'b1;
        @(negedge clk_125m);
        tick();
        rx_ack          = 1'b0;
        ram_uart_up_len = 13'h0ff;
        for (int k = 1; k <= 24; k++) begin
            if (k > 1) tick();
            @(negedge clk_125m);
            rxExp = {(k <= CH) ? 1'b1 : 1'b0,
                     (k >= CH + TMO + 2) ? 1'b1 : 1'b0,
                     (k == CH + TMO + 1) ? 1'b1 : 1'b0};
            rxAct = {ram_uart_up_clr, rx_irq, rx_err};
            checkOutput($sformatf("rx_tmo_k%0d_clr_irq_err", k), rxAct, rxExp);
            if (k == 24) checkOutput("rx_tmo_recapture", rx_len, 13'h0ff);
        end
        tick();
        rx_ack           = 1'b1;
        ram_uart_up_flag = 1'b0;
        tick();
        rx_ack = 1'b0;
        repeat (12) @(negedge clk_125m);
        checkOutput("rx_tmo_settled", {ram_uart_up_clr, rx_irq, rx_err}, 0);

        // Reset in the middle of the start window.
        tick();
        req0_valid = 1'b1;
        req0_len   = 8'd2;
        @(negedge clk_125m);
        checkOutput("rstmid_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk_125m);
        @(negedge clk_125m);
        checkOutput("rstmid_start_before", ram_uart_down_start, 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_start_dropped", ram_uart_down_start, 0);
        checkOutput("rstmid_busy", tx_busy, 0);
        checkOutput("rstmid_down_len", ram_uart_down_len, 0);
        doneSeen  = 0;
        startSeen = 0;
        repeat (3) begin
            @(negedge clk_125m);
            if (req0_done || req1_done) doneSeen++;
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_125m);
            if (req0_done || req1_done) doneSeen++;
            if (ram_uart_down_start || tx_busy) startSeen++;
        end
        checkOutput("rstmid_no_done", doneSeen, 0);
        checkOutput("rstmid_stays_idle", startSeen, 0);
        applyStimulus('{reqIdx: 1, len: 1, expDoneOff: 20, expStartFirst: 1, expStartCnt: 4});
        checkOutput("rstmid_new_ready", resReady, 2'b01);
        checkOutput("rstmid_new_done_off", resDoneOff, 20);
        checkOutput("rstmid_new_start_cnt", resStartCnt, 4);

        // Randomised requests against a timeline model of grants and completions.
        doReset();
        mActive = 1'b0; mPref = 1'b0; visOwner = 1'b0; visLen = 0;
        mG = 0; mL = 0; mDone = 0; mOwner = 1'b0;
        v[0] = 1'b0; v[1] = 1'b0; ln[0] = 0; ln[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!v[i] && $urandom_range(0, 2) == 0) begin
                    v[i]  = 1'b1;
                    ln[i] = int'($urandom_range(0, 3));
                end
            end
            req0_valid = v[0]; req0_len = 8'(ln[0]);
            req1_valid = v[1]; req1_len = 8'(ln[1]);
            @(negedge clk_125m);
            idle = !mActive || (c > mDone);
            eR0 = 1'b0; eR1 = 1'b0; sel = 1'b0;
            if (idle && (v[0] || v[1])) begin
`ifdef UART_SCHED_RR_EN
                sel = (v[0] && v[1]) ? mPref : v[1];
`else
                sel = !v[0];
`endif
                eR0 = !sel;
                eR1 = sel;
            end
            eBusy  = mActive && (c > mG) && (c <= mDone);
            eStart = mActive && (mL != 0) && (c >= mG + 1) && (c <= mG + SH);
            eD0    = mActive && (c == mDone) && !mOwner;
            eD1    = mActive && (c == mDone) && mOwner;
            expV = {eR0, eR1, eD0, eD1, eStart, eBusy, visOwner, 8'(visLen)};
            actV = {req0_ready, req1_ready, req0_done, req1_done, ram_uart_down_start,
                    tx_busy, tx_owner, ram_uart_down_len};
            checkOutput($sformatf("rand_cycle%0d", c), actV, expV);
            if (eR0 || eR1) begin
                mActive  = 1'b1;
                mG       = c;
                mL       = ln[sel];
                mOwner   = sel;
                mPref    = !sel;
                mDone    = (mL == 0) ? c + 1 : c + SH + mL * BC + GC + 1;
                v[sel]   = 1'b0;
                visOwner = sel;
                visLen   = mL;
            end
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waitIdle("rand_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_link_sched.md
# uart_link_sched

Scheduler that owns the UART frame buffers and sits between the host-side logic and the UART engine. It arbitrates two transmit requesters for the single downstream (TX) RAM/engine, sequences `ram_uart_down_start` and `ram_uart_down_len`, and estimates transmit completion with a byte-time timer. It also turns the upstream (RX) frame flag into an interrupt/acknowledge handshake and sequences `ram_uart_up_clr`.

## Interface
Parameters:
- START_HOLD, 4: cycles `ram_uart_down_start` is held high. Must be ≥4 so the engine's 3-FF synchroniser sees the edge.
- CLR_HOLD, 4: cycles `ram_uart_up_clr` is held high. Must be ≥4.
- BYTE_CYCLES, 10850: clk_125m cycles per UART character at the configured baud (10 bits).
- GUARD_CYCLES, 1000: extra cycles added after the last byte.
- FLAG_TMO, 1024: maximum cycles to wait for `ram_uart_up_flag` to fall after a clear.

Ports:
- clk_125m  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  TX request; held until ready
- req0_len / req1_len  in  8  bytes to send; stable while valid
- req0_ready / req1_ready  out  1  one-cycle grant
- req0_done / req1_done  out  1  one-cycle completion pulse
- tx_busy  out  1  TX FSM not idle
- tx_owner  out  1  index of the last granted requester
- ram_uart_down_start  out  1  start level to the UART engine
- ram_uart_down_len  out  8  latched length of the granted request
- ram_uart_up_flag  in  1  RX frame complete (level)
- ram_uart_up_len  in  13  RX frame byte count
- ram_uart_up_clr  out  1  clear level to the UART engine
- rx_irq  out  1  frame pending, level
- rx_len  out  13  captured frame length
- rx_ack  in  1  one-cycle acknowledge from the host
- rx_err  out  1  one-cycle pulse; the flag failed to clear

## Operation
- TX FSM states: T_IDLE, T_START, T_WAIT, T_DONE.
- **T_IDLE, grant:** if any valid, select a requester per the arbitration rule.
  - The selected readyN is high combinationally that cycle.
  - reqN_len is latched into ram_uart_down_len; tx_owner is updated.
  - Go to T_START if len≠0. Go to T_DONE if len=0: no start is issued, because the engine treats len 0 as a 256-byte wrap.
- **T_START:** ram_uart_down_start=1 for START_HOLD cycles. Then load the wait counter with len*BYTE_CYCLES+GUARD_CYCLES and go to T_WAIT.
- **T_WAIT:** start=0; decrement the counter. At 0, go to T_DONE.
- **T_DONE:** doneN=1 for the owner for one cycle, then T_IDLE. A new grant is possible on the following cycle.
- **Counter width:** 24 bits unsigned. The parameters must satisfy 255*BYTE_CYCLES+GUARD_CYCLES < 2^24; the multiply is 8×24, truncated to 24 bits.
- RX FSM states: R_IDLE, R_PEND, R_CLR, R_DROP.
- **R_IDLE:** when up_flag=1, capture ram_uart_up_len into rx_len and go to R_PEND.
- **R_PEND:** rx_irq=1. On rx_ack, go to R_CLR. rx_ack in any other state is ignored.
- **R_CLR:** up_clr=1 for CLR_HOLD cycles, then go to R_DROP.
- **R_DROP:** up_clr=0; wait for up_flag=0, then go to R_IDLE.
  - If FLAG_TMO cycles elapse first: pulse rx_err and go to R_IDLE.
  - On timeout the flag is still high, so the frame is re-raised.
- The TX and RX FSMs are independent and run concurrently.
- **Reset:** all outputs are 0, both FSMs go idle, counters are 0, and the round-robin pointer prefers req0. A reset mid-operation drops start/clr immediately; no done pulse is issued.

## Timing
- **Grant:** at cycle t.
  - down_start is high on cycles t+1 … t+START_HOLD.
  - T_WAIT lasts len*BYTE_CYCLES+GUARD_CYCLES cycles.
  - done fires at t+START_HOLD+len*BYTE_CYCLES+GUARD_CYCLES+1.
- **Zero length:** grant at t, done at t+1.
- **Start low gap:** down_start low time between starts is ≥ BYTE_CYCLES+GUARD_CYCLES+2.
- **RX:** up_flag rising at cycle f gives rx_irq=1 from f+1.
  - rx_ack at cycle a drops rx_irq at a+1; up_clr is high on a+1 … a+CLR_HOLD.
- **Simultaneous grant:** if both requests are valid in the same T_IDLE cycle, exactly one ready fires.
- **Sampling:** rx_ack and up_flag are sampled on the same clock; no synchronisers are needed (single clock domain).

## Configuration
- UART_SCHED_RR_EN defined: round-robin. Priority goes to the requester not equal to tx_owner; after reset req0 wins.
- Undefined: fixed priority, req0 always wins; req1 is granted only when req0_valid=0.

## Test plan
Parameters used throughout: BYTE_CYCLES=10, GUARD_CYCLES=5, START_HOLD=4, CLR_HOLD=4, FLAG_TMO=16.
- **Single request:** req0 len=3 at cycle t → req0_ready at t; down_start high t+1..t+4; down_len=3; req0_done at t+40; tx_busy low at t+41.
- **Zero length:** req1 len=0 → ready at t, req1_done at t+1, down_start never high.
- **Contention:** both valid continuously, len=1 each. With RR_EN, grants alternate req0, req1, req0. Without RR_EN, req0 is granted every time and req1 is starved.
- **RX handshake:** drive up_flag=1 with up_len=0x012 → rx_irq=1, rx_len=0x012. Send rx_ack → up_clr high 4 cycles. Drop up_flag 3 cycles later → FSM back to R_IDLE, rx_irq=0, no rx_err.
- **RX timeout:** keep up_flag=1 after rx_ack → rx_err pulse 16 cycles after up_clr falls, then rx_irq re-asserts.
- **Reset mid-op:** assert rst_n=0 during T_START → down_start=0 immediately, no done, tx_busy=0. After release, a new request is granted normally.
